// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, reset vector, PC step and the
// {pc, instr} record that flows from fetch into the IF/ID register.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC      = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage connections: instruction-memory port, hazard/redirect inputs
// and the instruction presented to the IF/ID register.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-deep {pc, instr} buffer between the instruction memory and decode.
// Entry 0 is always the head; clear beats push and pop.
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry_q [2];
  logic [1:0]   count_q;
  logic         pop_eff;

  assign pop_eff = pop && (count_q != 2'd0);

  // NOTE: the storage is reset as well as the count, so a freshly reset
  // stage can never present an old instruction word even transiently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= 2'd0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else if (clear) begin
      count_q <= 2'd0;
    end else begin
      assert (!(push && !pop_eff && count_q == 2'd2));
      case ({push, pop_eff})
        2'b10: begin
          if (count_q != 2'd2) begin
            entry_q[count_q[0]] <= push_data;
            count_q             <= count_q + 2'd1;
          end
        end
        2'b01: begin
          entry_q[0] <= entry_q[1];
          count_q    <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            entry_q[0] <= push_data;
          end else begin
            entry_q[0] <= entry_q[1];
            entry_q[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = (count_q != 2'd0) ? entry_q[0] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a one-cycle-latency instruction
// memory and buffers returned words so a decode stall never loses a fetch.
module fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  localparam int unsigned XLEN = riscv_pkg::XLEN;

  logic [XLEN-1:0]        pc_q;
  logic                   inflight_q;
  logic [XLEN-1:0]        inflight_pc_q;
  logic                   kill_q;
  logic [1:0]             count;
  logic [1:0]             occupancy;
  logic                   pop;
  logic                   push;
  logic                   issue;
  riscv_pkg::fetch_entry_t push_data;
  riscv_pkg::fetch_entry_t head;

  assign pop       = bus.out_valid && !bus.stall && !bus.redirect_valid;
  // Buffered plus outstanding words after this cycle's pop; never above 2.
  assign occupancy = count + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = !bus.redirect_valid && (occupancy < 2'd2);
  assign push      = inflight_q && !kill_q;
  assign push_data = '{pc: inflight_pc_q, instr: bus.imem_rdata};

  // NOTE: every state register uses non-blocking assignments so all updates
  // see the pre-edge values, matching the flop behaviour being described.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q       <= bus.redirect_pc & riscv_pkg::PC_ALIGN_MASK;
      inflight_q <= 1'b0;
      kill_q     <= inflight_q;
    end else begin
      kill_q <= 1'b0;
      if (issue) begin
        pc_q          <= pc_q + riscv_pkg::PC_INC;
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based stream model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_fetch_stage;

  localparam logic [31:0] XOR_PAT  = 32'hFFFF_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  bit   checking = 1'b0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  fetch_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Synchronous instruction memories: word = address ^ XOR_PAT, one cycle late.
  logic [31:0] rd_addr  = '0;
  logic [31:0] rd_addr2 = '0;
  always @(posedge clk) begin
    if (bus.imem_req)  rd_addr  <= bus.imem_addr;
    if (bus2.imem_req) rd_addr2 <= bus2.imem_addr;
  end
  assign bus.imem_rdata  = rd_addr ^ XOR_PAT;
  assign bus2.imem_rdata = rd_addr2 ^ XOR_PAT;

  initial begin
    bus2.stall          = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Stream model: buffered PCs, the one outstanding fetch and the next PC.
  logic [31:0] mbuf[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_kill;
  logic [31:0] m_pc;

  always @(negedge clk) begin
    bit          m_valid, m_pop, m_issue;
    logic [31:0] m_head;
    m_valid = (mbuf.size() != 0);
    m_head  = m_valid ? mbuf[0] : 32'h0;
    m_pop   = m_valid && !bus.stall && !bus.redirect_valid;
    m_issue = !bus.redirect_valid && ((mbuf.size() + int'(m_pend) - int'(m_pop)) < 2);
    if (checking) begin
      check("model imem_req", {31'b0, bus.imem_req}, {31'b0, m_issue});
      if (m_issue) check("model imem_addr", bus.imem_addr, m_pc);
      check("model out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
      check("model out_pc", bus.out_pc, m_head);
      check("model out_instr", bus.out_instr, m_valid ? (m_head ^ XOR_PAT) : 32'h0);
    end
    if (!reset) begin
      mbuf.delete();
      m_pend = 1'b0;
      m_kill = 1'b0;
      m_pc   = 32'h0;
    end else if (bus.redirect_valid) begin
      mbuf.delete();
      m_kill = m_pend;
      m_pend = 1'b0;
      m_pc   = bus.redirect_pc & ~32'h3;
    end else begin
      if (m_pop) void'(mbuf.pop_front());
      if (m_pend && !m_kill) mbuf.push_back(m_pend_pc);
      m_kill = 1'b0;
      if (m_issue) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_pend = 1'b0;
      end
    end
  end

  // Inputs change 2 time units after an edge; literal checks follow 1 later.
  task automatic drive(input logic rst, input logic stl, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    reset              = rst;
    bus.stall          = stl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);

    // Cycle 0: reset released, first fetch from the reset vector.
    drive(1, 0, 0, 0);
    checking = 1'b1;
    check("reset imem_req", {31'b0, bus.imem_req}, 32'd1);
    check("reset imem_addr", bus.imem_addr, 32'h0);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset out_pc", bus.out_pc, 32'h0);
    check("reset out_instr", bus.out_instr, 32'h0);
    check("wrap first addr", bus2.imem_addr, WRAP_PC);
    drive(1, 0, 0, 0);                              // cycle 1
    check("c1 imem_addr", bus.imem_addr, 32'h4);
    check("c1 out_valid", {31'b0, bus.out_valid}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 2
    check("c2 out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("c2 out_pc", bus.out_pc, 32'h0);
    check("c2 out_instr", bus.out_instr, 32'hFFFF_0000);
    check("wrap c2 out_pc", bus2.out_pc, 32'hFFFF_FFF8);
    drive(1, 0, 0, 0);                              // cycle 3
    check("c3 out_pc", bus.out_pc, 32'h4);
    check("wrap c3 out_pc", bus2.out_pc, 32'hFFFF_FFFC);

    // Stall for 5 cycles while 8 is presented: 8 and C get buffered.
    drive(1, 1, 0, 0);                              // cycle 4
    check("stall c4 out_pc", bus.out_pc, 32'h8);
    check("stall c4 imem_req", {31'b0, bus.imem_req}, 32'd0);
    check("wrap c4 out_pc", bus2.out_pc, 32'h0);
    check("wrap c4 out_instr", bus2.out_instr, 32'hFFFF_0000);
    for (int i = 0; i < 4; i++) begin                // cycles 5..8
      drive(1, 1, 0, 0);
      check("stall hold out_pc", bus.out_pc, 32'h8);
      check("stall hold imem_req", {31'b0, bus.imem_req}, 32'd0);
    end
    drive(1, 0, 0, 0);                              // cycle 9
    check("release out_pc", bus.out_pc, 32'h8);
    check("release imem_addr", bus.imem_addr, 32'h10);
    drive(1, 0, 0, 0);                              // cycle 10
    check("drain out_pc C", bus.out_pc, 32'hC);
    drive(1, 0, 0, 0);                              // cycle 11
    check("drain out_pc 10", bus.out_pc, 32'h10);
    drive(1, 0, 0, 0);                              // cycle 12
    check("drain out_pc 14", bus.out_pc, 32'h14);

    // Redirect to 0x103 with a fetch in flight.
    drive(1, 0, 1, 32'h103);                        // cycle 13
    check("redir imem_req", {31'b0, bus.imem_req}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 14
    check("redir target addr", bus.imem_addr, 32'h100);
    check("redir flushed", {31'b0, bus.out_valid}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 15
    check("redir bubble", {31'b0, bus.out_valid}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 16
    check("redir out_pc", bus.out_pc, 32'h100);
    check("redir out_instr", bus.out_instr, 32'hFFFF_0100);
    drive(1, 0, 0, 0);                              // cycle 17
    check("redir next pc", bus.out_pc, 32'h104);

    // Fill the buffer under stall, then back-to-back redirects 0x200, 0x300.
    drive(1, 1, 0, 0);                              // cycle 18
    drive(1, 1, 1, 32'h200);                        // cycle 19
    check("full out_pc", bus.out_pc, 32'h108);
    check("full redir imem_req", {31'b0, bus.imem_req}, 32'd0);
    drive(1, 0, 1, 32'h300);                        // cycle 20
    check("redir2 cleared", {31'b0, bus.out_valid}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 21
    check("redir2 addr", bus.imem_addr, 32'h300);
    drive(1, 0, 0, 0);                              // cycle 22
    check("redir2 bubble", {31'b0, bus.out_valid}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 23
    check("redir2 out_pc", bus.out_pc, 32'h300);
    drive(1, 0, 0, 0);                              // cycle 24
    drive(1, 0, 0, 0);                              // cycle 25
    check("redir2 stream", bus.out_pc, 32'h308);

    // Fill the buffer again, then pulse reset for one cycle.
    drive(1, 1, 0, 0);                              // cycle 26
    drive(1, 1, 0, 0);                              // cycle 27
    check("pre-reset out_pc", bus.out_pc, 32'h30C);
    drive(0, 1, 0, 0);                              // cycle 28
    drive(1, 0, 0, 0);                              // cycle 29
    check("midreset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midreset imem_addr", bus.imem_addr, 32'h0);
    drive(1, 0, 0, 0);                              // cycle 30
    check("midreset bubble", {31'b0, bus.out_valid}, 32'd0);
    drive(1, 0, 0, 0);                              // cycle 31
    check("midreset out_pc", bus.out_pc, 32'h0);
    drive(1, 0, 0, 0);                              // cycle 32
    check("midreset next pc", bus.out_pc, 32'h4);
    repeat (4) drive(1, 0, 0, 0);

    @(posedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
